// File: rtl/wireout_sched_pkg.sv
// wireout_sched_pkg: shared state encoding, tag field positions and tag builder
package wireout_sched_pkg;

    typedef enum logic [1:0] {IDLE, PRESENT, ACK} state_t;

    localparam int TAG_VALID = 31;
    localparam int TAG_TMO   = 30;
    localparam int TAG_SEQ_H = 23;
    localparam int TAG_SEQ_L = 16;
    localparam int TAG_CH_H  = 3;
    localparam int TAG_CH_L  = 0;

    function automatic logic [31:0] make_tag(input logic tmo, input logic [7:0] seq, input logic [3:0] ch);
        logic [31:0] t;
        t                       = '0;
        t[TAG_VALID]            = 1'b1;
        t[TAG_TMO]              = tmo;
        t[TAG_SEQ_H:TAG_SEQ_L]  = seq;
        t[TAG_CH_H:TAG_CH_L]    = ch;
        return t;
    endfunction

endpackage

// File: rtl/wireout_rr_scheduler_arbiter.sv
// rr_arbiter: combinational first-requester-at-or-after-pointer search
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                     i_req,
    input  logic [(N > 1 ? $clog2(N) : 1)-1:0] i_ptr,
    output logic [N-1:0]                     o_grant,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] o_idx
);

    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic          w_found;
    logic [PW-1:0] w_j;

    // walk the channels cyclically from the pointer and take the first one set
    always_comb begin
        w_found = 1'b0;
        w_j     = '0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_j = PW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/wireout_rr_scheduler.sv
// wireout_rr_scheduler: round-robin sharing of one data/tag WireOut pair among status producers
module wireout_rr_scheduler
    import wireout_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WAIT_MAX = 0
) (
    input  logic                  ti_clk,
    input  logic                  ti_reset,
    input  logic                  ti_wireupdate,
    input  logic [NUM_CH-1:0]     req,
    input  logic [32*NUM_CH-1:0]  req_data,
    output logic [NUM_CH-1:0]     ack,
    output logic [31:0]           ep_data,
    output logic [31:0]           ep_tag,
    output logic                  busy
);

    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW = WAIT_MAX > 0 ? $clog2(WAIT_MAX + 1) : 1;

    state_t            r_state;
    logic [CW-1:0]     r_ptr;
    logic [CW-1:0]     r_ch;
    logic [NUM_CH-1:0] r_gnt;
    logic [7:0]        r_seq;
    logic              r_tflag;
    logic [TW-1:0]     r_tcnt;

    logic [NUM_CH-1:0] w_gnt;
    logic [CW-1:0]     w_idx;
    logic [CW-1:0]     w_ptr_next;
    logic [31:0]       w_word;
    logic              w_tmo;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_idx)
    );

    assign w_word     = req_data[32*int'(w_idx) +: 32];
    assign w_ptr_next = (r_ch == CW'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
    assign w_tmo      = (WAIT_MAX > 0) && (r_tcnt == TW'(WAIT_MAX - 1));

    // grant, hold the word until the host strobe captures it, then pulse ack for one cycle
    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_ch    <= '0;
            r_gnt   <= '0;
            r_seq   <= '0;
            r_tflag <= 1'b0;
            r_tcnt  <= '0;
            ack     <= '0;
            ep_data <= '0;
            ep_tag  <= '0;
            busy    <= 1'b0;
        end else begin
            ack <= '0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state <= PRESENT;
                        r_ch    <= w_idx;
                        r_gnt   <= w_gnt;
                        r_tcnt  <= '0;
                        ep_data <= w_word;
                        ep_tag  <= make_tag(r_tflag, r_seq, 4'(w_idx));
                        busy    <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (ti_wireupdate) begin
                        r_state           <= ACK;
                        ack               <= r_gnt;
                        r_seq             <= r_seq + 8'd1;
                        r_ptr             <= w_ptr_next;
                        ep_tag[TAG_VALID] <= 1'b0;
                    end else if (w_tmo) begin
                        r_state           <= IDLE;
                        r_tflag           <= 1'b1;
                        r_ptr             <= w_ptr_next;
                        ep_tag[TAG_VALID] <= 1'b0;
                        busy              <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                ACK: begin
                    r_state           <= IDLE;
                    ep_tag[TAG_VALID] <= 1'b0;
                    busy              <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
